// File: rtl/att_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the address translation table loader and its consumers.
package att_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } att_state_e;

    // Default geometry of the table.
    localparam int ATT_CLAUSE_COUNT = 20;
    localparam int ATT_VAW          = 11;
    localparam int ATT_CTAW         = 11;

    // Packs {row, mask}. The mask occupies the low mask_w bits and the row sits
    // directly above it. Callers cast the result down to their entry width.
    // Valid for mask_w <= 32 and row + mask widths <= 64.
    function automatic logic [63:0] att_pack_entry(input logic [31:0] row,
                                                   input logic [31:0] mask,
                                                   input int          mask_w);
        return (64'(row) << mask_w) | 64'(mask);
    endfunction

endpackage

// File: rtl/att_mask_gen.sv
`timescale 1ns/1ps
// Count to thermometer occupancy mask. Counts above CLAUSE_COUNT saturate to
// all ones and raise the over-range flag.
module att_mask_gen #(
    parameter  int CLAUSE_COUNT = 20,
    localparam int CW           = $clog2(CLAUSE_COUNT + 1)
) (
    input  logic [CW-1:0]           cnt,
    output logic [CLAUSE_COUNT-1:0] mask,
    output logic                    over
);

    // Bit i is set when more than i clauses reference the literal.
    for (genvar i = 0; i < CLAUSE_COUNT; i++) begin : g_bit
        assign mask[i] = (cnt > CW'(i));
    end

    assign over = (cnt > CW'(CLAUSE_COUNT));

endmodule

// File: rtl/att_loader.sv
`timescale 1ns/1ps
// Setup-time writer for the address translation table: sweeps the table to zero,
// then turns the {literal, clause count} stream into one {row, mask} entry per
// literal, allocating clause-table rows in order. All outputs are registered.
module att_loader
    import att_pkg::*;
#(
    parameter  int CLAUSE_COUNT               = ATT_CLAUSE_COUNT,
    parameter  int VARIABLE_ADDRESS_WIDTH     = ATT_VAW,
    parameter  int CLAUSE_TABLE_ADDRESS_WIDTH = ATT_CTAW,
    localparam int CW                         = $clog2(CLAUSE_COUNT + 1),
    localparam int WIDTH                      = CLAUSE_TABLE_ADDRESS_WIDTH + CLAUSE_COUNT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [VARIABLE_ADDRESS_WIDTH:0]       lit_i,
    input  logic [CW-1:0]                         cnt_i,
    input  logic                                  last_i,
    output logic                                  wr_en_o,
    output logic [VARIABLE_ADDRESS_WIDTH:0]       wr_addr_o,
    output logic [WIDTH-1:0]                      data_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [1:0]                            err_o,
    output logic [CLAUSE_TABLE_ADDRESS_WIDTH:0]   rows_used_o
);

    localparam int VAW  = VARIABLE_ADDRESS_WIDTH;
    localparam int CTAW = CLAUSE_TABLE_ADDRESS_WIDTH;
    // Row pointer value meaning every clause-table row has been handed out.
    localparam logic [CTAW:0] ROW_LIMIT = {1'b1, {CTAW{1'b0}}};

    att_state_e state_q, state_d;

    logic [VAW-1:0]          sweep_q;
    logic [VAW-1:0]          sweep_next;
    logic                    sweep_last;
    logic [CTAW:0]           row_q;
    logic                    row_full;
    logic [CTAW-1:0]         row_field;
    logic [CLAUSE_COUNT-1:0] mask;
    logic                    over;
    logic                    accept;
    logic                    has_clauses;
    logic [WIDTH-1:0]        entry;

    att_mask_gen #(
        .CLAUSE_COUNT (CLAUSE_COUNT)
    ) u_mask_gen (
        .cnt  (cnt_i),
        .mask (mask),
        .over (over)
    );

    assign sweep_next  = sweep_q + VAW'(1);
    assign sweep_last  = (sweep_q == '1);
    assign accept      = in_valid_i && in_ready_o;
    assign has_clauses = (cnt_i != '0);
    // Once rows run out, further literals all point at the last row.
    assign row_full    = (row_q == ROW_LIMIT);
    assign row_field   = row_full ? '1 : row_q[CTAW-1:0];
    // A literal with no clauses gets an all-zero entry, row field included.
    assign entry       = has_clauses ?
                         WIDTH'(att_pack_entry(32'(row_field), 32'(mask), CLAUSE_COUNT)) :
                         '0;
    assign rows_used_o = row_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; start is only honoured while not busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i)            state_d = CLEAR;
            CLEAR:      if (sweep_last)         state_d = LOAD;
            LOAD:       if (accept && last_i)   state_d = DONE;
            default:                            state_d = IDLE;
        endcase
    end

    // Write port, status flags, row allocation and sweep counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            data_o     <= '0;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= '0;
            row_q      <= '0;
            sweep_q    <= '0;
        end else begin
            wr_en_o    <= 1'b0;
            in_ready_o <= (state_d == LOAD);
            busy_o     <= (state_d == CLEAR) || (state_d == LOAD);
            // done rises the cycle after the final write, i.e. second cycle in DONE.
            done_o     <= (state_q == DONE) && (state_d == DONE);
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= '0;
                        data_o    <= '0;
                        sweep_q   <= '0;
                        row_q     <= '0;
                        err_o     <= '0;
                    end
                end
                CLEAR: begin
                    if (!sweep_last) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= {1'b0, sweep_next};
                        data_o    <= '0;
                        sweep_q   <= sweep_next;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= lit_i;
                        data_o    <= entry;
                        if (has_clauses) begin
                            if (row_full) err_o[1] <= 1'b1;
                            else          row_q    <= row_q + (CTAW+1)'(1);
                            if (over)     err_o[0] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_att_loader.sv
`timescale 1ns/1ps
// Self-checking bench for att_loader with a small table (8 entries, 4 rows).
module tb_att_loader;

    localparam int CC    = 20;
    localparam int VAW   = 3;
    localparam int CTAW  = 2;
    localparam int CW    = $clog2(CC + 1);
    localparam int WIDTH = CTAW + CC;
    localparam int DEPTH = 1 << VAW;
    localparam int ROWS  = 1 << CTAW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [VAW:0]     lit_i;
    logic [CW-1:0]    cnt_i;
    logic             last_i;
    logic             wr_en_o;
    logic [VAW:0]     wr_addr_o;
    logic [WIDTH-1:0] data_o;
    logic             busy_o;
    logic             done_o;
    logic [1:0]       err_o;
    logic [CTAW:0]    rows_used_o;

    att_loader #(
        .CLAUSE_COUNT               (CC),
        .VARIABLE_ADDRESS_WIDTH     (VAW),
        .CLAUSE_TABLE_ADDRESS_WIDTH (CTAW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .lit_i       (lit_i),
        .cnt_i       (cnt_i),
        .last_i      (last_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rows_used_o (rows_used_o)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    // Reference model: rows handed out so far and sticky error bits.
    int         m_row;
    logic [1:0] m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected entry from the allocation rules, using the current model row count.
    function automatic logic [63:0] exp_entry(input int c);
        logic [63:0] m;
        int          row;
        if (c == 0) return 64'd0;
        m   = (c > CC) ? ((64'd1 << CC) - 64'd1) : ((64'd1 << c) - 64'd1);
        row = (m_row >= ROWS) ? ROWS - 1 : m_row;
        return (64'(row) << CC) | m;
    endfunction

    task automatic model_accept(input int c);
        if (c > 0) begin
            if (m_row >= ROWS) m_err[1] = 1'b1;
            else               m_row++;
            if (c > CC)        m_err[0] = 1'b1;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en_o),     64'd0);
        chk({tag, "_addr"},  64'(wr_addr_o),   64'd0);
        chk({tag, "_data"},  64'(data_o),      64'd0);
        chk({tag, "_rdy"},   64'(in_ready_o),  64'd0);
        chk({tag, "_busy"},  64'(busy_o),      64'd0);
        chk({tag, "_done"},  64'(done_o),      64'd0);
        chk({tag, "_err"},   64'(err_o),       64'd0);
        chk({tag, "_rows"},  64'(rows_used_o), 64'd0);
    endtask

    // Start pulse and full sweep; beats and a stray start are offered meanwhile.
    task automatic do_clear();
        start_i = 1'b1; in_valid_i = 1'b1; lit_i = 4'd5; cnt_i = CW'(3); last_i = 1'b0;
        tick();
        start_i = 1'b0;
        m_row = 0; m_err = 2'b00;
        chk("clr_done", 64'(done_o),      64'd0);
        chk("clr_err",  64'(err_o),       64'd0);
        chk("clr_rows", 64'(rows_used_o), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            chk("clr_en",   64'(wr_en_o),    64'd1);
            chk("clr_addr", 64'(wr_addr_o),  64'(k));
            chk("clr_data", 64'(data_o),     64'd0);
            chk("clr_busy", 64'(busy_o),     64'd1);
            chk("clr_rdy",  64'(in_ready_o), 64'd0);
            start_i = (k == 3);
            tick();
        end
        start_i = 1'b0; in_valid_i = 1'b0;
        chk("load_en",   64'(wr_en_o),    64'd0);
        chk("load_rdy",  64'(in_ready_o), 64'd1);
        chk("load_busy", 64'(busy_o),     64'd1);
    endtask

    // One LOAD cycle; the write for an accepted beat must show right after the edge.
    task automatic beat(input bit v, input int l, input int c, input bit lst);
        logic [63:0] e;
        in_valid_i = v; lit_i = (VAW+1)'(l); cnt_i = CW'(c); last_i = lst;
        chk("beat_rdy", 64'(in_ready_o), 64'd1);
        e = 64'd0;
        if (v) begin
            e = exp_entry(c);
            model_accept(c);
        end
        tick();
        in_valid_i = 1'b0; last_i = 1'b0;
        chk("beat_en", 64'(wr_en_o), 64'(v));
        if (v) begin
            chk("beat_addr", 64'(wr_addr_o), 64'(l));
            chk("beat_data", 64'(data_o),    e);
        end
        chk("beat_rows", 64'(rows_used_o), 64'(m_row));
        chk("beat_err",  64'(err_o),       64'(m_err));
    endtask

    // Called right after the final write has issued.
    task automatic end_session();
        chk("end_rdy",  64'(in_ready_o), 64'd0);
        chk("end_busy", 64'(busy_o),     64'd0);
        chk("end_done", 64'(done_o),     64'd0);
        tick();
        chk("fin_done", 64'(done_o),      64'd1);
        chk("fin_busy", 64'(busy_o),      64'd0);
        chk("fin_en",   64'(wr_en_o),     64'd0);
        chk("fin_rows", 64'(rows_used_o), 64'(m_row));
        chk("fin_err",  64'(err_o),       64'(m_err));
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
        lit_i = '0; cnt_i = '0; last_i = 1'b0;
        m_row = 0; m_err = 2'b00;
        tick(); tick();
        chk_quiet("rst");
        rst_n = 1'b1;
        tick();
        chk_quiet("idle");

        // Sweep, then three back-to-back beats.
        do_clear();
        beat(1, 2, 3, 0);
        beat(1, 5, 1, 0);
        beat(1, 6, 0, 1);
        end_session();
        chk("t2_rows", 64'(rows_used_o), 64'd2);

        // Beats offered in DONE are dropped.
        in_valid_i = 1'b1; lit_i = 4'd1; cnt_i = CW'(2);
        tick(); tick();
        chk("done_no_wr", 64'(wr_en_o), 64'd0);
        chk("done_hold",  64'(done_o),  64'd1);
        in_valid_i = 1'b0;

        // Over-range count, then row exhaustion; a start during LOAD is ignored.
        do_clear();
        beat(1, 1, 25, 0);
        chk("t3_err", 64'(err_o), 64'd1);
        beat(1, 3, 1, 0);
        start_i = 1'b1;
        beat(1, 4, 1, 0);
        start_i = 1'b0;
        beat(1, 9, 1, 0);
        beat(1, 7, 20, 1);
        end_session();

        // Exactly five single-clause beats into four rows.
        do_clear();
        for (int i = 0; i < 5; i++) beat(1, i, 1, i == 4);
        end_session();
        chk("t4_err",  64'(err_o),       64'd2);
        chk("t4_rows", 64'(rows_used_o), 64'd4);

        // Valid toggling every other cycle.
        do_clear();
        for (int i = 0; i < 12; i++) beat(i % 2 == 1, i % 8, (i % 5) + 1, i == 11);
        end_session();

        // Random beats: valid gaps, out-of-range literals and counts.
        do_clear();
        for (int i = 0; i < 40; i++) begin
            bit v;
            v = ($urandom_range(0, 1) == 1) || (i == 39);
            beat(v, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), i == 39);
        end
        end_session();

        // Reset during the sweep aborts it; a new start sweeps from zero.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0; in_valid_i = 1'b1;
        tick();
        chk_quiet("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_idle_en",   64'(wr_en_o), 64'd0);
        chk("rst_idle_busy", 64'(busy_o),  64'd0);
        in_valid_i = 1'b0;
        do_clear();
        beat(1, 3, 2, 1);
        end_session();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
